// File: rtl/sobel_stream_ctrl_if.sv
// Stream/kernel bundle for the Sobel frame controller: pixel input handshake,
// window taps to the kernel, kernel result return, result output handshake
// and frame status.
interface sobel_stream_ctrl_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pix;
    logic [7:0] win_p0;
    logic [7:0] win_p1;
    logic [7:0] win_p2;
    logic [7:0] win_p3;
    logic [7:0] win_p5;
    logic [7:0] win_p6;
    logic [7:0] win_p7;
    logic [7:0] win_p8;
    logic [7:0] edge_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pix;
    logic       busy;
    logic       frame_done;

    // Environment side: pixel source, kernel and result sink
    modport master (
        output start, in_valid, in_pix, edge_in, out_ready,
        input  in_ready, win_p0, win_p1, win_p2, win_p3, win_p5,
               win_p6, win_p7, win_p8, out_valid, out_pix, busy, frame_done
    );

    // Controller side
    modport slave (
        input  start, in_valid, in_pix, edge_in, out_ready,
        output in_ready, win_p0, win_p1, win_p2, win_p3, win_p5,
               win_p6, win_p7, win_p8, out_valid, out_pix, busy, frame_done
    );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// Streaming frame controller for a 3x3 Sobel kernel: two line buffers feed a
// 3x3 window whose taps go to an external combinational kernel; the kernel
// result is registered into a valid/ready output stream, one per interior pixel.
module sobel_stream_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 7
) (
    input logic                 clk,
    input logic                 rst_n,
    sobel_stream_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam int            LB_DEPTH = 1 << CW;

    logic [1:0]    r_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [7:0]    r_win [0:8];
    logic          r_win_valid;
    logic          r_out_valid;
    logic [7:0]    r_out_pix;
    logic          r_frame_done;

    // Line buffers are deliberately left unreset; a window is only marked
    // valid once both buffers hold rows of the current frame.
    logic [7:0]    r_lb0 [0:LB_DEPTH-1];
    logic [7:0]    r_lb1 [0:LB_DEPTH-1];

    logic          w_advance;
    logic          w_accept;
    logic          w_interior;

    assign w_advance  = !r_out_valid || bus.out_ready;
    assign w_accept   = (r_state == S_RUN) && bus.in_valid && w_advance;
    assign w_interior = (r_row >= CW'(2)) && (r_col >= CW'(2));

    assign bus.in_ready   = (r_state == S_RUN) && w_advance;
    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_pix    = r_out_pix;
    assign bus.frame_done = r_frame_done;
    assign bus.win_p0     = r_win[0];
    assign bus.win_p1     = r_win[1];
    assign bus.win_p2     = r_win[2];
    assign bus.win_p3     = r_win[3];
    assign bus.win_p5     = r_win[5];
    assign bus.win_p6     = r_win[6];
    assign bus.win_p7     = r_win[7];
    assign bus.win_p8     = r_win[8];

    // Frame sequencing: raster counters, run/drain states and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            if (r_row == LAST_ROW) begin
                                r_row   <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_row <= r_row + CW'(1);
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_win_valid && !r_out_valid) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Window shift on accept; window validity moves only when the output can take it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (w_advance) begin
            r_win_valid <= w_accept && w_interior;
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= r_lb1[r_col];
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= r_lb0[r_col];
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= bus.in_pix;
            end
        end
    end

    // Line buffer update: older row moves up, new pixel enters the newer row
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= bus.in_pix;
        end
    end

    // Result register: captures the kernel output for the current window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_win_valid;
            r_out_pix   <= bus.edge_in;
        end
    end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench for sobel_stream_ctrl on an 8x6 frame with a behavioural
// Sobel kernel (|gx|+|gy| saturated) returning edge_in.
module tb_sobel_stream_ctrl;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int N    = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  img [0:N-1];
    logic [7:0]  expQ [$];
    logic [7:0]  got [$];
    logic [63:0] tapLog [$];
    int          doneCount  = 0;
    int          outsAtDone = 0;
    logic        prevWinValid = 1'b0;

    always #5 clk = ~clk;

    sobel_stream_ctrl_if bus();

    sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] sobel(input logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8);
        int gx;
        int gy;
        int m;
        gx = (int'(a2) + 2 * int'(a5) + int'(a8)) - (int'(a0) + 2 * int'(a3) + int'(a6));
        gy = (int'(a6) + 2 * int'(a7) + int'(a8)) - (int'(a0) + 2 * int'(a1) + int'(a2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 255) m = 255;
        return m[7:0];
    endfunction

    // Behavioural kernel closing the loop on the window taps
    assign bus.edge_in = sobel(bus.win_p0, bus.win_p1, bus.win_p2, bus.win_p3,
                               bus.win_p5, bus.win_p6, bus.win_p7, bus.win_p8);

    // Passive monitor: output transfers, done pulses and first-valid window taps
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_pix);
            if (bus.frame_done) begin
                doneCount  = doneCount + 1;
                outsAtDone = got.size();
            end
            if (dut.r_win_valid && !prevWinValid)
                tapLog.push_back({bus.win_p0, bus.win_p1, bus.win_p2, bus.win_p3,
                                  bus.win_p5, bus.win_p6, bus.win_p7, bus.win_p8});
        end
        prevWinValid = rst_n ? dut.r_win_valid : 1'b0;
    end

    function automatic void fillImage(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       img[r*W+c] = 8'((r * 16 + c) & 255);
                    1:       img[r*W+c] = 8'd50;
                    2:       img[r*W+c] = (c < 4) ? 8'd0 : 8'd200;
                    default: img[r*W+c] = 8'((r * 29 + c * c * 7 + (r ^ c) * 3) & 255);
                endcase
            end
        end
        expQ.delete();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                expQ.push_back(sobel(img[(r-1)*W+c-1], img[(r-1)*W+c], img[(r-1)*W+c+1],
                                     img[r*W+c-1], img[r*W+c+1],
                                     img[(r+1)*W+c-1], img[(r+1)*W+c], img[(r+1)*W+c+1]));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Runs one frame (or its first stopAfter pixels) starting from IDLE at posedge+1
    task automatic applyStimulus(input int gapPct, input int stallPct, input int stopAfter,
                                 input bit doStall, input bit pokeStart);
        int         idx = 0;
        int         cyc = 0;
        int         stallLeft = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = '0;
        int         doneBase;
        doneBase = doneCount;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (idx < stopAfter && cyc < 3000) begin
            bus.in_valid = ($urandom_range(99) >= gapPct);
            bus.in_pix   = img[idx];
            bus.start    = pokeStart && (idx == 10);
            if (doStall && !stalled && bus.out_valid) begin
                stalled   = 1'b1;
                stallLeft = 5;
                held      = bus.out_pix;
            end
            if (stallLeft > 0) bus.out_ready = 1'b0;
            else               bus.out_ready = ($urandom_range(99) >= stallPct);
            @(negedge clk);
            if (stallLeft > 0) begin
                checkOutput("stall_out_pix", bus.out_pix, held);
                checkOutput("stall_in_ready", bus.in_ready, 0);
                checkOutput("stall_out_valid", bus.out_valid, 1);
                stallLeft--;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        checkOutput("accept_bound", idx, stopAfter);
        if (stopAfter == N) begin
            cyc = 0;
            while (doneCount == doneBase && cyc < 500) begin
                bus.out_ready = ($urandom_range(99) >= stallPct);
                @(posedge clk); #1;
                cyc++;
            end
            bus.out_ready = 1'b1;
            repeat (5) @(posedge clk);
            #1;
        end
    endtask

    task automatic verifyFrame(input string tag, input int gotBase, input int doneBase);
        checkOutput({tag, "_count"}, got.size() - gotBase, NOUT);
        for (int i = 0; i < NOUT; i++)
            if (gotBase + i < got.size())
                checkOutput($sformatf("%s_pix%0d", tag, i), got[gotBase+i], expQ[i]);
        checkOutput({tag, "_done_pulses"}, doneCount - doneBase, 1);
        checkOutput({tag, "_outs_before_done"}, outsAtDone - gotBase, NOUT);
        checkOutput({tag, "_busy_idle"}, bus.busy, 0);
        checkOutput({tag, "_in_ready_idle"}, bus.in_ready, 0);
    endtask

    initial begin
        int gb;
        int db;
        int tb0;
        int nz;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pix    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_pix", bus.out_pix, 0);
        checkOutput("rst_frame_done", bus.frame_done, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_win_p8", bus.win_p8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] ramp frame");
        fillImage(0);
        gb = got.size(); db = doneCount; tb0 = tapLog.size();
        applyStimulus(0, 0, N, 1'b0, 1'b0);
        verifyFrame("ramp", gb, db);
        checkOutput("ramp_first_taps_hi", (tapLog.size() > tb0) ? tapLog[tb0][63:32] : 32'hx, 32'h0001_0210);
        checkOutput("ramp_first_taps_lo", (tapLog.size() > tb0) ? tapLog[tb0][31:0]  : 32'hx, 32'h1220_2122);
        checkOutput("ramp_first_value", (got.size() > gb) ? got[gb] : 8'hx, 136);

        $display("[TB] constant frame");
        fillImage(1);
        gb = got.size(); db = doneCount;
        applyStimulus(0, 0, N, 1'b0, 1'b0);
        verifyFrame("const", gb, db);
        nz = 0;
        for (int i = gb; i < got.size(); i++) if (got[i] != 0) nz++;
        checkOutput("const_nonzero", nz, 0);

        $display("[TB] vertical step frame");
        fillImage(2);
        gb = got.size(); db = doneCount;
        applyStimulus(0, 0, N, 1'b0, 1'b0);
        verifyFrame("step", gb, db);
        nz = 0;
        for (int i = gb; i < got.size(); i++) if (got[i] != 0) nz++;
        checkOutput("step_nonzero", nz, 8);
        checkOutput("step_col3", (got.size() > gb + 2) ? got[gb+2] : 8'hx, 255);
        checkOutput("step_col1", (got.size() > gb) ? got[gb] : 8'hx, 0);

        $display("[TB] backpressure hold");
        fillImage(3);
        gb = got.size(); db = doneCount;
        applyStimulus(0, 0, N, 1'b1, 1'b0);
        verifyFrame("stall", gb, db);

        $display("[TB] random gaps and backpressure");
        gb = got.size(); db = doneCount;
        applyStimulus(50, 40, N, 1'b0, 1'b0);
        verifyFrame("random", gb, db);

        $display("[TB] start during run");
        gb = got.size(); db = doneCount;
        applyStimulus(20, 20, N, 1'b0, 1'b1);
        verifyFrame("restart_ignored", gb, db);

        $display("[TB] reset mid-frame");
        fillImage(0);
        db = doneCount;
        applyStimulus(0, 0, 2 * W + 3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_out_pix", bus.out_pix, 136);
        checkOutput("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_pix", bus.out_pix, 0);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_win_p5", bus.win_p5, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrst_no_done", doneCount - db, 0);
        checkOutput("midrst_idle_in_ready", bus.in_ready, 0);
        fillImage(3);
        gb = got.size(); db = doneCount;
        applyStimulus(0, 10, N, 1'b0, 1'b0);
        verifyFrame("after_reset", gb, db);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
